data_mem_access_ctrl: RTL and testbench

// - MEM-stage sequencer between the pipeline and the handshaked data memory.
// - Accepts one load/store per instruction, drives word-aligned memory strobes and byte enables.
// - Waits out memBusyWait and stalls the pipeline meanwhile.
// - Returns byte/half/word load data aligned and sign/zero-extended, ready for writeback.

---
 rtl/data_mem_access_ctrl_if.sv | 35 +++
 rtl/data_mem_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_data_mem_access_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_access_ctrl_if.sv
// Pipeline/data-memory bundle for the MEM-stage access sequencer.
// slave is the sequencer side; master is the pipeline plus memory side.
interface data_mem_access_ctrl_if;
  logic        reqRead;
  logic        reqWrite;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] storeData;
  logic        stall;
  logic [31:0] loadData;
  logic        loadValid;
  logic        busError;
  logic        misalignFault;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [3:0]  memByteEnable;
  logic        memBusyWait;
  logic [31:0] memReadData;

  modport slave (
    input  reqRead, reqWrite, funct3, address, storeData,
    input  memBusyWait, memReadData,
    output stall, loadData, loadValid, busError, misalignFault,
    output memRead, memWrite, memAddress, memWriteData, memByteEnable
  );

  modport master (
    output reqRead, reqWrite, funct3, address, storeData,
    output memBusyWait, memReadData,
    input  stall, loadData, loadValid, busError, misalignFault,
    input  memRead, memWrite, memAddress, memWriteData, memByteEnable
  );
endinterface

// File: rtl/data_mem_access_ctrl.sv
// MEM-stage load/store sequencer with lane steering and load extension.
// Optional misaligned-access trap: define MISALIGN_TRAP_EN.
module data_mem_access_ctrl #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam bit HAS_LIM = (WAIT_LIMIT != 0);
  localparam logic [CNT_W-1:0] LIM_M1 =
    CNT_W'(HAS_LIM ? WAIT_LIMIT - 1 : 0);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic             req, bad;
  logic             take, trap, finish, abort;
  logic             mem_rd, mem_wr;
  logic [31:0]      mem_addr, mem_wd, load_q;
  logic [3:0]       mem_en;
  logic             lv_q, be_q, mf_q;

  function automatic logic [1:0] shamt(
    input logic [2:0] f, input logic [1:0] a);
    shamt = 2'b00;
    unique case (1'b1)
      f[1:0] == 2'b00: shamt = a;
      f[1:0] == 2'b01: shamt = {a[1], 1'b0};
      default: ;
    endcase
  endfunction

  function automatic logic [3:0] lanes(
    input logic [2:0] f, input logic [1:0] a);
    lanes = 4'b1111;
    unique case (1'b1)
      f[1:0] == 2'b00: lanes = 4'b0001 << a;
      f[1:0] == 2'b01: lanes = 4'b0011 << {a[1], 1'b0};
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] wdata(
    input logic [2:0] f, input logic [31:0] d);
    wdata = d;
    unique case (1'b1)
      f[1:0] == 2'b00: wdata = {4{d[7:0]}};
      f[1:0] == 2'b01: wdata = {2{d[15:0]}};
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] conv(
    input logic [2:0] f, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = w >> {shamt(f, a), 3'b000};
    conv = s;
    unique case (1'b1)
      f == 3'b000: conv = {{24{s[7]}}, s[7:0]};
      f == 3'b100: conv = {24'b0, s[7:0]};
      f == 3'b001: conv = {{16{s[15]}}, s[15:0]};
      f == 3'b101: conv = {16'b0, s[15:0]};
      default: ;
    endcase
  endfunction

  assign req = bus.reqRead | bus.reqWrite;

`ifdef MISALIGN_TRAP_EN
  assign bad = ((bus.funct3[1:0] == 2'b01) & bus.address[0])
             | (bus.funct3[1] & (|bus.address[1:0]));
`else
  assign bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    trap    = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: if (req) begin
        if (bad) begin
          trap    = 1'b1;
          state_n = DONE;
        end else begin
          take    = 1'b1;
          state_n = ACCESS;
        end
      end
      ACCESS: if (!bus.memBusyWait) begin
        finish  = 1'b1;
        state_n = DONE;
      end else if (HAS_LIM && cnt == LIM_M1) begin
        abort   = 1'b1;
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      mem_en   <= '0;
      load_q   <= '0;
      lv_q     <= 1'b0;
      be_q     <= 1'b0;
      mf_q     <= 1'b0;
    end else begin
      lv_q <= 1'b0;
      be_q <= 1'b0;
      mf_q <= 1'b0;
      if (take) begin
        cnt      <= '0;
        off_q    <= bus.address[1:0];
        f3_q     <= bus.funct3;
        mem_rd   <= bus.reqRead;
        mem_wr   <= ~bus.reqRead;
        mem_addr <= {bus.address[31:2], 2'b00};
        mem_wd   <= wdata(bus.funct3, bus.storeData);
        mem_en   <= lanes(bus.funct3, bus.address[1:0]);
      end
      if (trap) begin
        load_q <= '0;
        mf_q   <= 1'b1;
      end
      if (state == ACCESS && bus.memBusyWait)
        cnt <= cnt + 1'b1;
      if (finish) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
        load_q <= mem_rd ? conv(f3_q, off_q, bus.memReadData) : '0;
        lv_q   <= mem_rd;
      end
      // timeout: drop the strobe and hand back a zero result
      if (abort) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
        load_q <= '0;
        be_q   <= 1'b1;
      end
    end
  end

  assign bus.stall         = (state == IDLE && req) || state == ACCESS;
  assign bus.loadData      = load_q;
  assign bus.loadValid     = lv_q;
  assign bus.busError      = be_q;
  assign bus.misalignFault = mf_q;
  assign bus.memRead       = mem_rd;
  assign bus.memWrite      = mem_wr;
  assign bus.memAddress    = mem_addr;
  assign bus.memWriteData  = mem_wd;
  assign bus.memByteEnable = mem_en;
endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Directed bench for data_mem_access_ctrl with a per-cycle reference model.
// Honours MISALIGN_TRAP_EN when it is defined for the build.
module tb_data_mem_access_ctrl;
  localparam int WL = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   stall_cnt = 0;

  data_mem_access_ctrl_if bus ();

  data_mem_access_ctrl #(.WAIT_LIMIT(WL), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  bit          chk_on = 1'b0;
  bit          e_stall, e_rd, e_wr, e_lv, e_be, e_mf, e_ldchk;
  logic [31:0] e_addr, e_wd, e_ld;
  logic [3:0]  e_en;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: access size, aligned lane offset, lane data
  function automatic int size_of(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int off_of(input logic [2:0] f, input logic [31:0] a);
    int b;
    b = int'(a % 4);
    return b - (b % size_of(f));
  endfunction

  function automatic logic [3:0] m_en(input logic [2:0] f,
                                      input logic [31:0] a);
    int m;
    m = ((1 << size_of(f)) - 1) << off_of(f, a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f,
                                       input logic [31:0] d);
    if (size_of(f) == 1) return d[7:0] * 32'h01010101;
    if (size_of(f) == 2) return d[15:0] * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f,
                                       input logic [31:0] a,
                                       input logic [31:0] w);
    longint unsigned mask;
    logic [31:0] v;
    int n;
    n = size_of(f);
    v = w >> (8 * off_of(f, a));
    if (n < 4) begin
      mask = (64'd1 << (8 * n)) - 1;
      v = v & mask[31:0];
      if (!f[2] && v[8*n-1]) v = v | ~mask[31:0];
    end
    return v;
  endfunction

  function automatic bit m_mis(input logic [2:0] f, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (a % size_of(f)) != 0;
`else
    return (f === 3'bxxx) && (a === 32'hx);
`endif
  endfunction

  task automatic set_exp(input bit st, input bit rd, input bit wr,
                         input bit lv, input bit be, input bit mf,
                         input bit ldc);
    e_stall = st; e_rd = rd; e_wr = wr;
    e_lv = lv; e_be = be; e_mf = mf; e_ldchk = ldc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      if (bus.stall === 1'b1) stall_cnt++;
      chk("stall", 32'(bus.stall), 32'(e_stall));
      chk("memRead", 32'(bus.memRead), 32'(e_rd));
      chk("memWrite", 32'(bus.memWrite), 32'(e_wr));
      chk("loadValid", 32'(bus.loadValid), 32'(e_lv));
      chk("busError", 32'(bus.busError), 32'(e_be));
      chk("misalignFault", 32'(bus.misalignFault), 32'(e_mf));
      if (e_rd || e_wr) begin
        chk("memAddress", bus.memAddress, e_addr);
        chk("memByteEnable", 32'(bus.memByteEnable), 32'(e_en));
      end
      if (e_wr) chk("memWriteData", bus.memWriteData, e_wd);
      if (e_ldchk) chk("loadData", bus.loadData, e_ld);
    end
  end

  task automatic txn(input bit rd, input bit wr, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] w, input int nbusy,
                     input int stalls_lit);
    bit mis, tmo;
    int nacc, exp_st;
    mis  = m_mis(f, a);
    tmo  = !mis && WL != 0 && nbusy >= WL;
    nacc = mis ? 0 : (tmo ? WL : nbusy + 1);
    exp_st = (stalls_lit >= 0) ? stalls_lit : nacc + 1;
    bus.reqRead = rd; bus.reqWrite = wr; bus.funct3 = f;
    bus.address = a; bus.storeData = sd; bus.memReadData = w;
    bus.memBusyWait = 1'b0;
    e_addr = {a[31:2], 2'b00};
    e_en   = m_en(f, a);
    e_wd   = m_wd(f, sd);
    e_ld   = (rd && !mis && !tmo) ? m_ld(f, a, w) : 32'h0;
    stall_cnt = 0;
    set_exp(1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < nacc; k++) begin
      bus.memBusyWait = (k < nbusy);
      set_exp(1, rd, !rd, 0, 0, 0, 0);
      tick();
    end
    bus.memBusyWait = 1'b0;
    set_exp(0, 0, 0, rd && !mis && !tmo, tmo, mis, rd || mis || tmo);
    tick();
    bus.reqRead = 1'b0; bus.reqWrite = 1'b0;
    set_exp(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.reqRead = 1'b0; bus.reqWrite = 1'b0; bus.funct3 = 3'b000;
    bus.address = 32'h0; bus.storeData = 32'h0;
    bus.memBusyWait = 1'b0; bus.memReadData = 32'h0;
    set_exp(0, 0, 0, 0, 0, 0, 0);
    e_addr = 0; e_wd = 0; e_ld = 0; e_en = 0;
    tick(); tick();
    chk("rst stall", 32'(bus.stall), 32'h0);
    chk("rst memRead", 32'(bus.memRead), 32'h0);
    chk("rst memWrite", 32'(bus.memWrite), 32'h0);
    chk("rst memAddress", bus.memAddress, 32'h0);
    chk("rst memWriteData", bus.memWriteData, 32'h0);
    chk("rst memByteEnable", 32'(bus.memByteEnable), 32'h0);
    chk("rst loadData", bus.loadData, 32'h0);
    chk("rst pulses", {29'b0, bus.loadValid, bus.busError, bus.misalignFault},
        32'h0);
    reset = 1'b0;
    chk_on = 1'b1;
    tick();

    // literal pins for the model
    chk("pin lb data", m_ld(3'b000, 32'h1003, 32'h80FF1234), 32'hFFFFFF80);
    chk("pin lb en", 32'(m_en(3'b000, 32'h1003)), 32'h8);
    chk("pin lhu data", m_ld(3'b101, 32'h2002, 32'hBEEF0000), 32'h0000BEEF);
    chk("pin sb en", 32'(m_en(3'b000, 32'h3001)), 32'h2);
    chk("pin sb wd", m_wd(3'b000, 32'h000000AB), 32'hABABABAB);
    chk("pin sh wd", m_wd(3'b001, 32'h1234CDEF), 32'hCDEFCDEF);
    chk("pin lh data", m_ld(3'b001, 32'h6002, 32'h80017FFF), 32'hFFFF8001);

    txn(1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF1234, 0, 2);
    txn(1, 0, 3'b101, 32'h2002, 32'h0, 32'hBEEF0000, 3, 5);
    txn(0, 1, 3'b000, 32'h3001, 32'h000000AB, 32'h0, 0, 2);
    txn(1, 0, 3'b010, 32'h5000, 32'h0, 32'h12345678, 10, 5);

    // reset lands during the second ACCESS cycle
    bus.reqRead = 1'b1; bus.funct3 = 3'b010; bus.address = 32'h4000;
    bus.memBusyWait = 1'b1;
    e_addr = 32'h4000; e_en = 4'hF;
    set_exp(1, 0, 0, 0, 0, 0, 0);
    tick();
    set_exp(1, 1, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1; bus.reqRead = 1'b0;
    tick();
    reset = 1'b0; bus.memBusyWait = 1'b0;
    set_exp(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    txn(1, 0, 3'b010, 32'h4004, 32'h0, 32'h0BADF00D, 1, 3);

    txn(1, 0, 3'b001, 32'h6002, 32'h0, 32'h80017FFF, 0, 2);
    txn(1, 0, 3'b100, 32'h6000, 32'h0, 32'h12345680, 2, 4);
    txn(1, 0, 3'b000, 32'h6000, 32'h0, 32'h0000007F, 0, 2);
    txn(0, 1, 3'b001, 32'h7002, 32'h1234CDEF, 32'h0, 1, 3);
    txn(0, 1, 3'b010, 32'h7004, 32'hDEADBEEF, 32'h0, 0, 2);
    txn(1, 1, 3'b010, 32'h8000, 32'h55555555, 32'hCAFEF00D, 0, 2);
    txn(1, 0, 3'b111, 32'h9000, 32'h0, 32'h11223344, 0, 2);
    txn(1, 0, 3'b010, 32'h1002, 32'h0, 32'hA5A5F00F, 0, -1);
    txn(0, 1, 3'b001, 32'hA001, 32'h00003344, 32'h0, 0, -1);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
